// File: rtl/call_scheduler_pkg.sv
// Shared floor labels, direction codes and scheduler state encoding for the
// elevator call scheduler and anything that talks to it.
package call_scheduler_pkg;

    localparam logic [1:0] F1    = 2'b00;
    localparam logic [1:0] F2    = 2'b01;
    localparam logic [1:0] F3    = 2'b10;
    localparam logic [1:0] F_INV = 2'b11;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_SOS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_SOS  = 2'b11
    } state_t;

endpackage

// File: rtl/call_scheduler_button_debounce.sv
// Per-button debouncer: accepts a new level after it has been stable for
// DEBOUNCE_CYCLES cycles and emits one registered pulse on each rising level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_q;
    logic             r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
            // The count only advances while raw disagrees with the accepted level.
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/call_scheduler.sv
// Elevator call scheduler: debounced buttons feed a pending-request register,
// and a SCAN FSM picks the registered goal floor and travel direction.
module call_scheduler
    import call_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic [1:0] floor,
    input  logic       moving,
    input  logic       door_open,
    input  logic       sos_mode,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] goal_floor,
    output logic       goal_valid,
    output logic [1:0] dir
);

    logic [2:0] w_raw;
    logic [2:0] w_level;
    logic [2:0] w_press;
    logic [2:0] w_accept;
    logic [2:0] w_at;
    logic [2:0] w_above;
    logic [2:0] w_below;
    logic [2:0] w_pend_next;
    logic       w_floor_ok;
    logic       w_any_above;
    logic       w_any_below;
    logic [1:0] w_low_above;
    logic [1:0] w_high_below;

    state_t     r_state, w_state_next;
    logic [2:0] r_pend;
    logic [1:0] r_goal, w_goal_next;
    logic [1:0] r_dir, w_dir_next;
    logic       r_goal_valid, w_valid_next;

    assign w_raw = {button3, button2, button1};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (w_raw[g]),
            .level(w_level[g]),
            .press(w_press[g])
        );
    end

    // A press only counts while its button is still debounced-high.
    assign w_accept   = w_press & w_level;
    assign w_floor_ok = (floor != F_INV);
    assign w_at[0]    = (floor == F1) & ~moving & door_open;
    assign w_at[1]    = (floor == F2) & ~moving & door_open;
    assign w_at[2]    = (floor == F3) & ~moving & door_open;

    // Clear wins over set, so a press at the floor being served is absorbed.
    always_comb begin
        w_pend_next = '0;
        if (!sos_mode) begin
            w_pend_next = (r_pend | ((r_state == ST_SOS) ? 3'b000 : w_accept)) & ~w_at;
        end
    end

    always_comb begin
        w_above = '0;
        w_below = '0;
        case (floor)
            F1:      w_above = r_pend & 3'b110;
            F2:      begin
                         w_above = r_pend & 3'b100;
                         w_below = r_pend & 3'b001;
                     end
            F3:      w_below = r_pend & 3'b011;
            default: ;
        endcase
    end

    assign w_any_above  = |w_above;
    assign w_any_below  = |w_below;
    assign w_low_above  = w_above[1] ? F2 : F3;
    assign w_high_below = w_below[1] ? F2 : F1;

    always_comb begin
        w_state_next = r_state;
        w_goal_next  = r_goal;
        w_dir_next   = r_dir;
        w_valid_next = r_goal_valid;
        if (sos_mode) begin
            w_state_next = ST_SOS;
            w_goal_next  = F1;
            w_dir_next   = DIR_SOS;
        end else if (w_floor_ok) begin
            if (r_state == ST_SOS) begin
                w_state_next = ST_IDLE;
                w_goal_next  = floor;
                w_dir_next   = DIR_IDLE;
            end else if (w_any_above && (r_state != ST_DOWN || !w_any_below)) begin
                // Keep going the current way while work remains in that direction.
                w_state_next = ST_UP;
                w_goal_next  = w_low_above;
                w_dir_next   = DIR_UP;
            end else if (w_any_below) begin
                w_state_next = ST_DOWN;
                w_goal_next  = w_high_below;
                w_dir_next   = DIR_DOWN;
            end else begin
                w_state_next = ST_IDLE;
                w_goal_next  = floor;
                w_dir_next   = DIR_IDLE;
            end
        end
        if (sos_mode || w_floor_ok) begin
            w_valid_next = (w_goal_next != floor);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pend       <= '0;
            r_goal       <= F1;
            r_dir        <= DIR_IDLE;
            r_goal_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pend       <= w_pend_next;
            r_goal       <= w_goal_next;
            r_dir        <= w_dir_next;
            r_goal_valid <= w_valid_next;
        end
    end

    assign led1       = r_pend[0];
    assign led2       = r_pend[1];
    assign led3       = r_pend[2];
    assign goal_floor = r_goal;
    assign goal_valid = r_goal_valid;
    assign dir        = r_dir;

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: a table of held-input steps with expected outputs
// checked through a queue, plus hand sequences for debounce timing and reset.
module tb_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       button1, button2, button3;
    logic [1:0] floor;
    logic       moving, door_open, sos_mode;
    logic       led1, led2, led3;
    logic [1:0] goal_floor;
    logic       goal_valid;
    logic [1:0] dir;

    always #5 clk = ~clk;

    call_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button1   (button1),
        .button2   (button2),
        .button3   (button3),
        .floor     (floor),
        .moving    (moving),
        .door_open (door_open),
        .sos_mode  (sos_mode),
        .led1      (led1),
        .led2      (led2),
        .led3      (led3),
        .goal_floor(goal_floor),
        .goal_valid(goal_valid),
        .dir       (dir)
    );

    // Observed vector: {led3, led2, led1, goal_floor, goal_valid, dir}
    logic [7:0] obs;
    assign obs = {led3, led2, led1, goal_floor, goal_valid, dir};

    typedef struct {
        string      name;
        logic [2:0] btn;
        logic [1:0] flr;
        logic       mv;
        logic       dr;
        logic       sos;
        int         cyc;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic logic [7:0] pk(input logic [2:0] l, input logic [1:0] g,
                                      input logic v, input logic [1:0] d);
        return {l, g, v, d};
    endfunction

    task automatic add(input string n, input logic [2:0] b, input logic [1:0] f,
                       input logic mv, input logic dr, input logic s, input int c,
                       input logic [7:0] e);
        vec_t v;
        v.name = n; v.btn = b; v.flr = f; v.mv = mv; v.dr = dr; v.sos = s;
        v.cyc = c; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check_obs(input string name);
        logic [7:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b (led3 led2 led1 goal valid dir)",
                         name, obs, e);
            end
        end
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            {button3, button2, button1} = tbl[i].btn;
            floor     = tbl[i].flr;
            moving    = tbl[i].mv;
            door_open = tbl[i].dr;
            sos_mode  = tbl[i].sos;
            exp_q.push_back(tbl[i].exp);
            repeat (tbl[i].cyc) @(posedge clk);
            #1;
            check_obs(tbl[i].name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        //   name          btn     flr    mv dr sos cyc expected
        add("idle_f1",     3'b000, 2'b00, 0, 0, 0, 2, pk(3'b000, 2'b00, 0, 2'b00));
        add("retarget_f2", 3'b010, 2'b00, 1, 0, 0, 7, pk(3'b110, 2'b01, 1, 2'b01));
        add("step_f2",     3'b000, 2'b01, 1, 0, 0, 1, pk(3'b110, 2'b10, 1, 2'b01));
        add("clear_f2",    3'b000, 2'b01, 0, 1, 0, 2, pk(3'b100, 2'b10, 1, 2'b01));
        add("tie_in_up",   3'b001, 2'b01, 0, 1, 0, 7, pk(3'b101, 2'b10, 1, 2'b01));
        add("arrive_f3",   3'b000, 2'b10, 0, 1, 0, 2, pk(3'b001, 2'b00, 1, 2'b10));
        add("simul_at2",   3'b100, 2'b10, 0, 1, 0, 8, pk(3'b001, 2'b00, 1, 2'b10));
        add("arrive_f1",   3'b000, 2'b00, 0, 1, 0, 5, pk(3'b000, 2'b00, 0, 2'b00));
        add("tie_idle",    3'b101, 2'b01, 0, 0, 0, 7, pk(3'b101, 2'b10, 1, 2'b01));
        add("add_f2",      3'b010, 2'b01, 1, 0, 0, 7, pk(3'b111, 2'b10, 1, 2'b01));
        add("clear_f1",    3'b000, 2'b00, 0, 1, 0, 2, pk(3'b110, 2'b01, 1, 2'b01));
        add("at_f3_turn",  3'b000, 2'b10, 0, 0, 0, 1, pk(3'b110, 2'b01, 1, 2'b10));
        add("sos_enter",   3'b000, 2'b10, 0, 0, 1, 1, pk(3'b000, 2'b00, 1, 2'b11));
        add("sos_ignore",  3'b111, 2'b10, 0, 0, 1, 8, pk(3'b000, 2'b00, 1, 2'b11));
        add("sos_release", 3'b000, 2'b00, 0, 0, 0, 5, pk(3'b000, 2'b00, 0, 2'b00));
        add("press_f2",    3'b010, 2'b00, 1, 0, 0, 7, pk(3'b010, 2'b01, 1, 2'b01));
        add("floor_inv",   3'b000, 2'b11, 0, 1, 0, 2, pk(3'b010, 2'b01, 1, 2'b01));
        add("arrive_f2",   3'b000, 2'b01, 0, 1, 0, 2, pk(3'b000, 2'b01, 0, 2'b00));
        add("pre_reset",   3'b101, 2'b01, 0, 0, 0, 7, pk(3'b101, 2'b10, 1, 2'b01));

        rst = 1'b1;
        {button3, button2, button1} = 3'b000;
        floor = 2'b00; moving = 1'b0; door_open = 1'b0; sos_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(8'h00);
        check_obs("reset_init");
        @(negedge clk);
        rst = 1'b0;

        run_rows(0, 0);

        // Glitch of three cycles must not register.
        @(negedge clk);
        button3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        button3 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        exp_q.push_back(pk(3'b000, 2'b00, 0, 2'b00));
        check_obs("glitch_no_press");

        // Held press: led3 rises exactly 6 cycles after the raw edge.
        @(negedge clk);
        button3 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (led3 !== (k >= 6)) begin
                n_errors++;
                $display("FAIL led3_latency cycle %0d: got %b expected %b", k, led3, (k >= 6));
            end
        end
        exp_q.push_back(pk(3'b100, 2'b10, 1, 2'b01));
        check_obs("press_f3_goal");
        repeat (3) @(posedge clk);

        run_rows(1, tbl.size() - 1);

        // Asynchronous reset mid-operation, away from any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        {button3, button2, button1} = 3'b000;
        #1;
        exp_q.push_back(8'h00);
        check_obs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(8'h00);
        check_obs("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(pk(3'b000, 2'b01, 0, 2'b00));
        check_obs("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
